af_sweep_ctrl: RTL and testbench

AF_SWEEP_CTRL -- requirements
Module: af_sweep_ctrl

---
 rtl/af_sweep_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_af_sweep_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/af_sweep_ctrl.sv
// rtl/af_sweep_ctrl.sv - contrast-detect autofocus: luma edge sharpness per frame driving a coarse/fine lens sweep
// Optional fine pass enabled by defining AF_FINE_PASS_EN.
`timescale 1ns/1ps
module af_sweep_ctrl #(
  parameter int PIX_W      = 8,
  parameter int STEP_W     = 10,
  parameter int SUM_W      = 32,
  parameter int COARSE_INC = 16,
  parameter int SETTLE_FR  = 2
) (
  input  logic              VIDEO_CLK,
  input  logic              RESET_n,
  input  logic [PIX_W-1:0]  iR,
  input  logic [PIX_W-1:0]  iG,
  input  logic [PIX_W-1:0]  iB,
  input  logic              VS,
  input  logic              ACTIV,
  input  logic              AUTO_FOC,
  input  logic [PIX_W-1:0]  TH,
  output logic [STEP_W-1:0] STEP,
  output logic [15:0]       VCM_DATA,
  output logic [SUM_W-1:0]  FOCUS_SUM,
  output logic              BUSY,
  output logic              VCM_END
);

  localparam int LW         = PIX_W + 10;
  localparam int STEP_MAX_I = (1 << STEP_W) - 1;

`ifdef AF_FINE_PASS_EN
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COARSE, S_FINE, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COARSE, S_DONE} state_t;
`endif

  logic [LW-1:0]    luma_full;
  logic [PIX_W-1:0] y_r, y_d1, y_d2, g_r, diff;
  logic             act_d1, act_d2, vs_r;
  logic             hit, boundary;
  logic [SUM_W-1:0] acc, focus_sum;

  assign luma_full = LW'(77) * LW'(iR) + LW'(150) * LW'(iG) + LW'(29) * LW'(iB);
  assign diff      = (y_r > y_d2) ? (y_r - y_d2) : (y_d2 - y_r);
  assign hit       = act_d2 && (g_r > TH);
  assign boundary  = VS && !vs_r;

  always_ff @(posedge VIDEO_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      y_r       <= '0;
      y_d1      <= '0;
      y_d2      <= '0;
      g_r       <= '0;
      act_d1    <= 1'b0;
      act_d2    <= 1'b0;
      vs_r      <= 1'b0;
      acc       <= '0;
      focus_sum <= '0;
    end else begin
      y_r    <= PIX_W'(luma_full >> 8);
      y_d1   <= y_r;
      y_d2   <= y_d1;
      g_r    <= diff;
      act_d1 <= ACTIV;
      act_d2 <= act_d1;
      vs_r   <= VS;
      // A qualifying pixel landing on the boundary cycle belongs to neither frame.
      if (boundary) begin
        focus_sum <= acc;
        acc       <= '0;
      end else if (hit && (acc != '1)) begin
        acc <= acc + 1'b1;
      end
    end
  end

  state_t           state, target;
  logic [3:0]       settle_cnt;
  logic [STEP_W-1:0] step, peak_step, best_step;
  logic [SUM_W-1:0] peak;
  logic             af_d, busy, vcm_end, better;

  assign better    = acc > peak;
  assign best_step = better ? step : peak_step;

`ifdef AF_FINE_PASS_EN
  logic [STEP_W-1:0] fine_end, fine_lo, fine_hi;

  always_comb begin
    fine_lo = '0;
    fine_hi = STEP_W'(STEP_MAX_I);
    if (int'(best_step) >= COARSE_INC)
      fine_lo = STEP_W'(int'(best_step) - COARSE_INC);
    if (int'(best_step) + COARSE_INC <= STEP_MAX_I)
      fine_hi = STEP_W'(int'(best_step) + COARSE_INC);
  end
`endif

  always_ff @(posedge VIDEO_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= S_IDLE;
      target     <= S_COARSE;
      settle_cnt <= '0;
      step       <= '0;
      peak       <= '0;
      peak_step  <= '0;
      af_d       <= 1'b1;  // AUTO_FOC held high through reset must not count as a rising edge
      busy       <= 1'b0;
      vcm_end    <= 1'b0;
`ifdef AF_FINE_PASS_EN
      fine_end   <= '0;
`endif
    end else begin
      af_d <= AUTO_FOC;
      if (!AUTO_FOC) begin
        state      <= S_IDLE;
        settle_cnt <= '0;
        step       <= '0;
        peak       <= '0;
        peak_step  <= '0;
        busy       <= 1'b0;
        vcm_end    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (!af_d) begin
            state      <= S_SETTLE;
            target     <= S_COARSE;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
          S_SETTLE: if (boundary) begin
            if (settle_cnt == 4'(SETTLE_FR - 1)) begin
              state      <= target;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
          S_COARSE: if (boundary) begin
            if (better) begin
              peak      <= acc;
              peak_step <= step;
            end
            if (int'(step) + COARSE_INC > STEP_MAX_I) begin
`ifdef AF_FINE_PASS_EN
              state    <= S_SETTLE;
              target   <= S_FINE;
              step     <= fine_lo;
              fine_end <= fine_hi;
`else
              state   <= S_DONE;
              step    <= best_step;
              busy    <= 1'b0;
              vcm_end <= 1'b1;
`endif
            end else begin
              state <= S_SETTLE;
              step  <= step + STEP_W'(COARSE_INC);
            end
          end
`ifdef AF_FINE_PASS_EN
          S_FINE: if (boundary) begin
            if (better) begin
              peak      <= acc;
              peak_step <= step;
            end
            if (step == fine_end) begin
              state   <= S_DONE;
              step    <= best_step;
              busy    <= 1'b0;
              vcm_end <= 1'b1;
            end else begin
              state <= S_SETTLE;
              step  <= step + 1'b1;
            end
          end
`endif
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign STEP      = step;
  assign VCM_DATA  = 16'({step, 4'hF});
  assign FOCUS_SUM = focus_sum;
  assign BUSY      = busy;
  assign VCM_END   = vcm_end;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// tb/tb_af_sweep_ctrl.sv - directed bench for af_sweep_ctrl (frame sums, sweep, abort, reset)
`timescale 1ns/1ps
module tb_af_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0, th = 8'd20;
  logic       vs = 1'b0, activ = 1'b0, auto_foc = 1'b1;
  logic [9:0] step;
  logic [15:0] vcm_data;
  logic [31:0] focus_sum;
  logic       busy, vcm_end;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  af_sweep_ctrl dut (
    .VIDEO_CLK(clk), .RESET_n(rst_n), .iR(r), .iG(g), .iB(b), .VS(vs), .ACTIV(activ),
    .AUTO_FOC(auto_foc), .TH(th), .STEP(step), .VCM_DATA(vcm_data), .FOCUS_SUM(focus_sum),
    .BUSY(busy), .VCM_END(vcm_end)
  );

  typedef struct {
    logic [7:0] r, g, b, off, th;
    int n, exp;
  } vec_t;

  vec_t vecs[11];

`ifdef AF_FINE_PASS_EN
  localparam int EXP_FINAL = 200;
  localparam logic [15:0] EXP_VCM = 16'h0C8F;
`else
  localparam int EXP_FINAL = 192;
  localparam logic [15:0] EXP_VCM = 16'h0C0F;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] pr, pg, pb, input logic act);
    r = pr; g = pg; b = pb; activ = act;
    tick();
  endtask

  // Columns come in pairs (off,off,on,on,...); idle pixels use the on colour so every active pixel sees an edge.
  task automatic frame(input logic [7:0] on_r, on_g, on_b, off, input int n, input int post);
    repeat (3) pix(on_r, on_g, on_b, 1'b0);
    for (int c = 0; c < n; c++) begin
      if (c[1]) pix(on_r, on_g, on_b, 1'b1);
      else      pix(off, off, off, 1'b1);
    end
    repeat (post) pix(on_r, on_g, on_b, 1'b0);
    vs = 1'b1;
    pix(on_r, on_g, on_b, 1'b0);
    vs = 1'b0;
  endtask

  task automatic model_frame();
    int s, d, n;
    s = int'(step);
    d = (s > 200) ? s - 200 : 200 - s;
    n = (d >= 40) ? 0 : 40 - d;
    frame(8'd255, 8'd255, 8'd255, 8'd0, n, 3);
  endtask

  task automatic grey_frame();
    frame(8'd128, 8'd128, 8'd128, 8'd128, 8, 3);
  endtask

  task automatic run_search(input logic grey);
    for (int f = 0; f < 400 && !vcm_end; f++) begin
      if (grey) begin
        grey_frame();
        chk("grey_sum", focus_sum, 0);
      end else begin
        model_frame();
      end
    end
    chk("search_completes", vcm_end, 1);
  endtask

  task automatic run_until_step(input int s);
    for (int f = 0; f < 400 && int'(step) != s; f++) model_frame();
    chk("reached_step", step, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_vcm_data"}, vcm_data, 16'h000F);
    chk({tag, "_focus_sum"}, focus_sum, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vcm_end"}, vcm_end, 0);
  endtask

  initial begin
    vecs[0]  = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd20,  64, 64};
    vecs[1]  = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd20,  64, 0};
    vecs[2]  = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd254, 64, 64};
    vecs[3]  = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd255, 64, 0};
    vecs[4]  = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd75,  16, 16};
    vecs[5]  = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd76,  16, 0};
    vecs[6]  = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd148, 20, 20};
    vecs[7]  = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd27,  10, 10};
    vecs[8]  = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd28,  10, 0};
    vecs[9]  = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd20,  0,  0};
    vecs[10] = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   5,  5};

    // Reset asserted with AUTO_FOC already high; outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) grey_frame();
    chk("no_start_after_reset_busy", busy, 0);
    chk("no_start_after_reset_step", step, 0);

    auto_foc = 1'b0;
    th = 8'd20;
    frame(8'd255, 8'd255, 8'd255, 8'd0, 0, 3);
    foreach (vecs[i]) begin
      th = vecs[i].th;
      frame(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].off, vecs[i].n, 3);
      chk($sformatf("vec%0d_sum", i), focus_sum, vecs[i].exp);
    end
    th = 8'd20;

    // Last pixel's hit coincides with the boundary cycle and is dropped from both frames.
    frame(8'd255, 8'd255, 8'd255, 8'd0, 8, 1);
    chk("boundary_drop_sum", focus_sum, 7);
    frame(8'd255, 8'd255, 8'd255, 8'd0, 0, 3);
    chk("after_drop_sum", focus_sum, 0);

    chk("idle_busy", busy, 0);
    auto_foc = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_step", step, 0);
    run_search(1'b0);
    chk("final_step", step, EXP_FINAL);
    chk("final_vcm_data", vcm_data, EXP_VCM);
    chk("final_busy", busy, 0);
    repeat (2) model_frame();
    chk("done_hold_step", step, EXP_FINAL);
    chk("done_hold_end", vcm_end, 1);

    auto_foc = 1'b0;
    tick();
    chk("drop_done_step", step, 0);
    chk("drop_done_end", vcm_end, 0);

    auto_foc = 1'b1;
    tick();
    run_search(1'b1);
    chk("grey_final_step", step, 0);
    chk("grey_final_end", vcm_end, 1);

    auto_foc = 1'b0;
    tick();
    auto_foc = 1'b1;
    tick();
    run_until_step(64);
    chk("mid_coarse_busy", busy, 1);
    auto_foc = 1'b0;
    tick();
    chk("abort_step", step, 0);
    chk("abort_busy", busy, 0);
    auto_foc = 1'b1;
    tick();
    chk("restart_busy", busy, 1);
    chk("restart_step", step, 0);

`ifdef AF_FINE_PASS_EN
    run_until_step(1008);
    run_until_step(177);
`else
    run_until_step(192);
`endif
    chk("pre_reset_sum", focus_sum, 16);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    tick();
    rst_n = 1'b1;
    repeat (3) grey_frame();
    chk("midrun_release_busy", busy, 0);
    chk("midrun_release_step", step, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
